cpu_control_fsm: RTL and testbench

Multi-cycle instruction sequencer for the simple CPU. It accepts one 16-bit instruction at a time and classifies its opcode as ALU, ALUI, move, movi or illegal. It then drives the register-file read/write ports and the ALU through fetch-decode-execute-writeback. It sits between the instruction source and the register file / ALU datapath, and it replaces the bare start_* strobes with a handshaked, timed control sequence.

---
 rtl/cpu_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the simple CPU.
// Takes one instruction through a valid/ready handshake, classifies its opcode,
// then steers the register-file ports and the ALU launch/complete handshake.
module cpu_control_fsm #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [3:0]       rf_raddr_a,
    output logic [3:0]       rf_raddr_b,
    output logic [3:0]       rf_waddr,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       alu_op,
    output logic             alu_b_imm,
    output logic [7:0]       imm,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TO_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ALU_WAIT,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        C_ALU,
        C_ALUI,
        C_MOVE,
        C_MOVI,
        C_ILL
    } class_e;

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              alu_start_q, alu_start_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;

    class_e            cls;
    logic [2:0]        dec_alu_op;
    logic              dec_b_imm;
    logic [3:0]        opcode;

    assign opcode = ir_q[15:12];

    // Opcode classification of the held instruction.
    always_comb begin
        cls        = C_ILL;
        dec_alu_op = 3'b000;
        dec_b_imm  = 1'b0;
        if (!opcode[3] && (opcode[2:0] != 3'b111)) begin
            cls        = C_ALU;
            dec_alu_op = opcode[2:0];
        end else if (opcode == 4'b0111) begin
            cls = C_MOVE;
        end else if (opcode == 4'b1000) begin
            cls        = C_ALUI;
            dec_alu_op = 3'b000;
            dec_b_imm  = 1'b1;
        end else if (opcode == 4'b1001) begin
            cls        = C_ALUI;
            dec_alu_op = 3'b001;
            dec_b_imm  = 1'b1;
        end else if (opcode == 4'b1111) begin
            cls = C_MOVI;
        end
    end

    // State, instruction register, timeout counter and pulse flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ir_q          <= 16'h0000;
            to_cnt_q      <= '0;
            alu_start_q   <= 1'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            to_cnt_q      <= to_cnt_d;
            alu_start_q   <= alu_start_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic; alu_start and illegal are registered one-cycle pulses.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        to_cnt_d      = to_cnt_q;
        alu_start_d   = 1'b0;
        illegal_d     = 1'b0;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE: begin
                if (run && instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_ALU, C_ALUI: begin
                        state_d     = S_ALU_WAIT;
                        alu_start_d = 1'b1;
                        to_cnt_d    = '0;
                    end
                    C_MOVE, C_MOVI: state_d = S_WB;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                endcase
            end
            S_ALU_WAIT: begin
                if (alu_done) begin
                    state_d  = S_WB;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Give up on a hung ALU; report it like an illegal instruction.
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                instr_count_d = instr_count_q + CNT_W'(1);
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state and IR only (instr_ready also gates on run).
    always_comb begin
        instr_ready = (state_q == S_IDLE) && run;
        busy        = (state_q != S_IDLE);
        rf_we       = (state_q == S_WB);
        rf_raddr_a  = (cls == C_ALUI) ? ir_q[11:8] : ir_q[7:4];
        rf_raddr_b  = ir_q[3:0];
        rf_waddr    = ir_q[11:8];
        imm         = ir_q[7:0];
        alu_op      = dec_alu_op;
        alu_b_imm   = dec_b_imm;
        case (cls)
            C_MOVE:  wb_sel = 2'b01;
            C_MOVI:  wb_sel = 2'b10;
            default: wb_sel = 2'b00;
        endcase
        alu_start   = alu_start_q;
        illegal     = illegal_q;
        instr_count = instr_count_q;
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus pushes hand-computed expected
// writeback/illegal events; a negedge monitor pops and compares them.
// The retire counter is built 4 bits wide so its wrap is reached quickly.
module tb_cpu_control_fsm;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             instr_valid;
    logic [15:0]      instr;
    logic             instr_ready;
    logic [3:0]       rf_raddr_a, rf_raddr_b, rf_waddr;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic [2:0]       alu_op;
    logic             alu_b_imm;
    logic [7:0]       imm;
    logic             alu_start;
    logic             alu_done;
    logic             busy;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    cpu_control_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr_valid(instr_valid),
        .instr(instr), .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a),
        .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_op(alu_op), .alu_b_imm(alu_b_imm), .imm(imm),
        .alu_start(alu_start), .alu_done(alu_done), .busy(busy),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;     // 0 = writeback, 1 = illegal pulse
        int         cyc;
        logic [3:0] waddr;
        logic [1:0] wb_sel;
        logic [7:0] imm;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       chk_alu;
        logic [2:0] alu_op;
        logic       b_imm;
        logic [CNT_W-1:0] count;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        int          kind;
        int          off;
        logic [3:0]  waddr;
        logic [1:0]  wb_sel;
        logic [7:0]  imm;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        chk_alu;
        logic [2:0]  alu_op;
        logic        b_imm;
        int          delay;
        int          starts;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   alu_starts = 0;
    int   alu_delay = -1;
    int   cd = -1;
    logic [CNT_W-1:0] cnt_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic vec_t mk(input logic [15:0] ins, input int kind, input int off,
                                input logic [3:0] waddr, input logic [1:0] sel,
                                input logic [7:0] im, input logic [3:0] ra,
                                input logic [3:0] rb, input logic chk_alu,
                                input logic [2:0] op, input logic bi,
                                input int delay, input int starts);
        vec_t v;
        v.ins = ins; v.kind = kind; v.off = off; v.waddr = waddr; v.wb_sel = sel;
        v.imm = im; v.ra = ra; v.rb = rb; v.chk_alu = chk_alu; v.alu_op = op;
        v.b_imm = bi; v.delay = delay; v.starts = starts;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // ALU model: raise alu_done for one cycle, alu_delay cycles after alu_start (-1 = never).
    always @(negedge clk) begin
        if (!rst_n) begin
            cd       = -1;
            alu_done = 1'b0;
        end else begin
            alu_done = 1'b0;
            if (alu_start) cd = alu_delay;
            if (cd == 0) begin
                alu_done = 1'b1;
                cd       = -1;
            end else if (cd > 0) begin
                cd--;
            end
        end
    end

    // Monitor: every writeback or illegal pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_start) alu_starts++;
            if (rf_we || illegal) begin
                if (sb.size() == 0) begin
                    fail_now($sformatf("unexpected event rf_we=%0b illegal=%0b", rf_we, illegal));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_kind", 32'(illegal), 32'(e.kind));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.kind == 0) begin
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                        chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
                        chk("imm", 32'(imm), 32'(e.imm));
                        chk("rf_raddr_a", 32'(rf_raddr_a), 32'(e.ra));
                        chk("rf_raddr_b", 32'(rf_raddr_b), 32'(e.rb));
                        chk("count_at_wb", 32'(instr_count), 32'(e.count));
                        if (e.chk_alu) begin
                            chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                            chk("alu_b_imm", 32'(alu_b_imm), 32'(e.b_imm));
                        end
                    end else begin
                        chk("busy_on_illegal", 32'(busy), 32'd0);
                        chk("rf_we_on_illegal", 32'(rf_we), 32'd0);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [15:0] ins, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            fail_now("instr_ready never rose");
            return;
        end
        instr       = ins;
        instr_valid = 1'b1;
        acc         = cyc;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now($sformatf("expected event missing (%0d pending)", sb.size()));
            sb.delete();
        end
    endtask

    task automatic push_exp(input vec_t v, input int acc);
        exp_t e;
        e.kind = v.kind; e.cyc = acc + v.off; e.waddr = v.waddr; e.wb_sel = v.wb_sel;
        e.imm = v.imm; e.ra = v.ra; e.rb = v.rb; e.chk_alu = v.chk_alu;
        e.alu_op = v.alu_op; e.b_imm = v.b_imm; e.count = cnt_model;
        if (v.kind == 0) cnt_model = cnt_model + CNT_W'(1);
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        int s0;
        alu_delay = v.delay;
        s0 = alu_starts;
        issue(v.ins, acc);
        if (acc < 0) return;
        push_exp(v, acc);
        drain();
        @(negedge clk);
        chk("ready_after", 32'(instr_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("alu_start_pulses", 32'(alu_starts - s0), 32'(v.starts));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   acc;
        vec_t v;

        rst_n = 1'b0; run = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        #12;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //          instr    kind off waddr sel   imm    ra    rb  alu  op    bimm dly st
        vecs[0] = mk(16'hF3A5, 0, 2, 4'h3, 2'b10, 8'hA5, 4'hA, 4'h5, 0, 3'd0, 0, -1, 0);
        vecs[1] = mk(16'h2412, 0, 5, 4'h4, 2'b00, 8'h12, 4'h1, 4'h2, 1, 3'd2, 0,  2, 1);
        vecs[2] = mk(16'h7C30, 0, 2, 4'hC, 2'b01, 8'h30, 4'h3, 4'h0, 0, 3'd0, 0, -1, 0);
        vecs[3] = mk(16'h8A05, 0, 3, 4'hA, 2'b00, 8'h05, 4'hA, 4'h5, 1, 3'd0, 1,  0, 1);
        vecs[4] = mk(16'h6123, 0, 4, 4'h1, 2'b00, 8'h23, 4'h2, 4'h3, 1, 3'd6, 0,  1, 1);
        vecs[5] = mk(16'h0312, 0, 3, 4'h3, 2'b00, 8'h12, 4'h1, 4'h2, 1, 3'd0, 0,  0, 1);
        vecs[6] = mk(16'h9507, 1, 2 + TIMEOUT, 4'h0, 2'b00, 8'h00, 4'h0, 4'h0, 0, 3'd0, 0, -1, 1);
        vecs[7] = mk(16'hC000, 1, 2, 4'h0, 2'b00, 8'h00, 4'h0, 4'h0, 0, 3'd0, 0, -1, 0);
        vecs[8] = mk(16'hA123, 1, 2, 4'h0, 2'b00, 8'h00, 4'h0, 4'h0, 0, 3'd0, 0, -1, 0);
        vecs[9] = mk(16'hE0FF, 1, 2, 4'h0, 2'b00, 8'h00, 4'h0, 4'h0, 0, 3'd0, 0, -1, 0);
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        chk("count_after_vectors", 32'(instr_count), 32'd6);

        // run low: instruction offered but never accepted
        @(negedge clk);
        run = 1'b0; instr = 16'hF111; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("runlow_ready", 32'(instr_ready), 32'd0);
            chk("runlow_busy", 32'(busy), 32'd0);
        end
        instr_valid = 1'b0; run = 1'b1;

        // run dropped mid-move: the move still retires
        v = mk(16'h7210, 0, 2, 4'h2, 2'b01, 8'h10, 4'h1, 4'h0, 0, 3'd0, 0, -1, 0);
        alu_delay = -1;
        issue(v.ins, acc);
        if (acc >= 0) push_exp(v, acc);
        run = 1'b0;
        drain();
        @(negedge clk);
        chk("rundrop_ready", 32'(instr_ready), 32'd0);
        chk("rundrop_count", 32'(instr_count), 32'd7);
        run = 1'b1;

        // async reset while waiting on a hung ALU
        alu_delay = -1;
        issue(16'h3456, acc);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_rf_we", 32'(rf_we), 32'd0);
        chk("midreset_alu_start", 32'(alu_start), 32'd0);
        chk("midreset_illegal", 32'(illegal), 32'd0);
        chk("midreset_count", 32'(instr_count), 32'd0);
        chk("midreset_ready", 32'(instr_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_model = '0;

        // counter wrap: 16 movi retirements take the 4-bit count back to 0
        for (int i = 0; i < 16; i++) begin
            logic [7:0] im;
            im = 8'(i);
            v = mk({4'hF, 4'h5, im}, 0, 2, 4'h5, 2'b10, im, 4'h0, im[3:0], 0, 3'd0, 0, -1, 0);
            run_vec(v);
        end
        chk("count_wrapped", 32'(instr_count), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
